// File: rtl/encode_pack_pkg.sv
// encode_pkg: shared types and width helpers for the encode_pack bit packer.
//   state_e    - packer FSM states (RUN / FLUSH / DONE)
//   acc_width  - ACC_W  = OUT_W + CODE_W - 1, widest bit backlog the accumulator holds
//   cnt_width  - CNTB_W = $clog2(OUT_W + CODE_W), width of the bit counter
package encode_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int acc_width(input int out_w, input int code_w);
        return out_w + code_w - 1;
    endfunction

    function automatic int cnt_width(input int out_w, input int code_w);
        return $clog2(out_w + code_w);
    endfunction

endpackage

// File: rtl/encode_pack_acc.sv
// encode_pack_acc: bit accumulator for the packer.
//   Holds the pending code bits (newest in the LSBs) and their count, masks
//   incoming codes to code_len bits, and extracts the oldest OUT_W bits
//   (word_o) or the zero-padded remainder (tail_word_o).
// Ports:
//   clk, rst_n, ce   clock, synchronous active-low reset, clock enable
//   accept_i         append code_data_i[code_len_i-1:0] this cycle
//   code_data_i      right-aligned code, bits at/above code_len_i ignored
//   code_len_i       number of valid code bits (0..CODE_W)
//   emit_i           oldest OUT_W bits leave this cycle
//   tail_i           remaining (< OUT_W) bits leave this cycle
//   full_o           at least OUT_W bits pending
//   empty_o          no bits pending
//   cnt_avail_o      bit count left after this cycle's emit
//   word_o           oldest OUT_W pending bits, first bit in MSB
//   tail_word_o      remaining bits left-justified, LSBs zero
module encode_pack_acc
    import encode_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int CODE_W = 13,
    parameter int LEN_W  = 4,
    // Derived widths; leave at their defaults.
    parameter int ACC_W  = acc_width(OUT_W, CODE_W),
    parameter int CNTB_W = cnt_width(OUT_W, CODE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              accept_i,
    input  logic [CODE_W-1:0] code_data_i,
    input  logic [LEN_W-1:0]  code_len_i,
    input  logic              emit_i,
    input  logic              tail_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNTB_W-1:0] cnt_avail_o,
    output logic [OUT_W-1:0]  word_o,
    output logic [OUT_W-1:0]  tail_word_o
);

    localparam logic [CNTB_W-1:0] OUT_WC = CNTB_W'(OUT_W);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNTB_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0] code_mask;
    logic [CODE_W-1:0] code_masked;

    // A shift by CODE_W clears the ones, so len == CODE_W keeps every bit.
    assign code_mask   = ~({CODE_W{1'b1}} << code_len_i);
    assign code_masked = code_data_i & code_mask;

    assign full_o      = (cnt_q >= OUT_WC);
    assign empty_o     = (cnt_q == '0);
    assign cnt_avail_o = emit_i ? cnt_q - OUT_WC : cnt_q;

    // Bits above cnt_q are stale history; both extractors truncate them away.
    assign word_o      = OUT_W'(acc_q >> (cnt_q - OUT_WC));
    assign tail_word_o = OUT_W'(acc_q << (OUT_WC - cnt_q));

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_avail_o;
        if (tail_i) begin
            cnt_d = '0;
        end
        // Emit reads the pre-shift acc_q, so accept and emit can share a cycle.
        if (accept_i) begin
            acc_d = (acc_q << code_len_i) | ACC_W'(code_masked);
            cnt_d = cnt_d + CNTB_W'(code_len_i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (ce) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/encode_pack.sv
// encode_pack: packs variable-length MSB-first codes into OUT_W-bit words.
// Ports:
//   clk, rst_n, ce          clock, synchronous active-low reset, clock enable
//   code_valid/code_ready   input code handshake
//   code_data, code_len     right-aligned code and its length (0..CODE_W)
//   finish                  end of stream, honoured only in RUN
//   data_o, valid_o         packed output word, first code bit in MSB
//   out_ready               downstream accepts when valid_o & out_ready & ce
//   done_o                  one-cycle pulse once the stream is fully emitted
//   word_cnt                words handed off in the current stream (saturating)
module encode_pack
    import encode_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int CODE_W = 13,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code_data,
    input  logic [LEN_W-1:0]  code_len,
    output logic              code_ready,
    input  logic              finish,
    output logic [OUT_W-1:0]  data_o,
    output logic              valid_o,
    input  logic              out_ready,
    output logic              done_o,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int CNTB_W = cnt_width(OUT_W, CODE_W);
    localparam logic [CNTB_W-1:0] OUT_WC = CNTB_W'(OUT_W);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   data_q;
    logic               valid_q;
    logic [CNT_W-1:0]   word_cnt_q;

    logic               full, empty;
    logic [CNTB_W-1:0]  cnt_avail;
    logic [OUT_W-1:0]   word, tail_word;
    logic               out_free, emit, tail, accept, handshake;

    // The output register can take a word when empty or being drained now.
    assign out_free  = !valid_q || out_ready;
    assign emit      = ce && full && out_free;
    assign tail      = ce && (state_q == FLUSH) && !full && !empty && out_free;
    assign accept    = code_valid && code_ready;
    assign handshake = ce && valid_q && out_ready;

    encode_pack_acc #(
        .OUT_W  (OUT_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .accept_i    (accept),
        .code_data_i (code_data),
        .code_len_i  (code_len),
        .emit_i      (emit),
        .tail_i      (tail),
        .full_o      (full),
        .empty_o     (empty),
        .cnt_avail_o (cnt_avail),
        .word_o      (word),
        .tail_word_o (tail_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (finish) state_d = FLUSH;
            // Leave only once every bit has been handed off downstream.
            FLUSH:   if (empty && !valid_q) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        done_o     = (state_q == DONE);
        code_ready = ce && (state_q == RUN) && (cnt_avail < OUT_WC);
    end

    // Output register and per-stream word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            word_cnt_q <= '0;
        end else if (ce) begin
            if (emit) begin
                data_q  <= word;
                valid_q <= 1'b1;
            end else if (tail) begin
                data_q  <= tail_word;
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            if (state_q == DONE) begin
                word_cnt_q <= '0;
            end else if (handshake && !(&word_cnt_q)) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_encode_pack.sv
// tb_encode_pack: self-checking bench for encode_pack (default parameters).
// A bit-queue reference model turns every accepted code into expected words
// on a scoreboard queue; each output handshake pops and compares one word.
module tb_encode_pack;

    localparam int OUT_W  = 16;
    localparam int CODE_W = 13;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 21;

    logic              clk = 1'b0;
    logic              rst_n, ce, code_valid, finish, out_ready;
    logic [CODE_W-1:0] code_data;
    logic [LEN_W-1:0]  code_len;
    logic              code_ready, valid_o, done_o;
    logic [OUT_W-1:0]  data_o;
    logic [CNT_W-1:0]  word_cnt;

    always #5 clk = ~clk;

    encode_pack #(
        .OUT_W  (OUT_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .code_valid (code_valid),
        .code_data  (code_data),
        .code_len   (code_len),
        .code_ready (code_ready),
        .finish     (finish),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .out_ready  (out_ready),
        .done_o     (done_o),
        .word_cnt   (word_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_hs  = -100;
    int exp_pushed = 0;
    logic [OUT_W-1:0] last_word;
    bit               mbits[$];
    logic [OUT_W-1:0] exp_q[$];

    typedef struct {
        logic              ce;
        logic              vld;
        logic [CODE_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic              ordy;
        logic              exp_rdy;
        logic              exp_valid;
        logic [OUT_W-1:0]  exp_data;
        logic [CNT_W-1:0]  exp_wc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void model_code(input logic [CODE_W-1:0] d, input logic [LEN_W-1:0] len);
        for (int i = int'(len) - 1; i >= 0; i--) mbits.push_back(d[i]);
        while (mbits.size() >= OUT_W) begin
            logic [OUT_W-1:0] w;
            for (int b = OUT_W - 1; b >= 0; b--) w[b] = mbits.pop_front();
            exp_q.push_back(w);
            exp_pushed++;
        end
    endfunction

    function automatic void model_flush();
        if (mbits.size() > 0) begin
            logic [OUT_W-1:0] w = '0;
            for (int b = OUT_W - 1; b >= 0 && mbits.size() > 0; b--) w[b] = mbits.pop_front();
            exp_q.push_back(w);
            exp_pushed++;
        end
    endfunction

    // Called just after a falling edge with inputs already driven; observes
    // the cycle, then advances to the next falling edge.
    task automatic tick();
        logic [OUT_W-1:0] exp_w;
        #1;
        assert (!(code_valid && code_len > LEN_W'(CODE_W)))
            else $error("FAIL illegal_code_len: got %0d limit %0d", code_len, CODE_W);
        if (!rst_n) begin
            mbits.delete();
            exp_q.delete();
        end else begin
            if (code_valid && code_ready) model_code(code_data, code_len);
            if (finish && ce) model_flush();
            if (valid_o && out_ready && ce) begin
                check("sb_word_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("sb_word", data_o, exp_w);
                end
                last_word = data_o;
                last_hs   = cyc;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic beat(input logic [CODE_W-1:0] d, input logic [LEN_W-1:0] l);
        code_valid = 1'b1;
        code_data  = d;
        code_len   = l;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_o) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_q.size() > 0 || valid_o); i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               seen;
        int               idx;
        int               base;
        bit               accepted;
        logic [OUT_W-1:0] held;
        logic [CODE_W-1:0] codes[40];

        rst_n = 1'b0; ce = 1'b1; code_valid = 1'b0; finish = 1'b0; out_ready = 1'b1;
        code_data = '0; code_len = '0; held = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_wc", word_cnt, 0);
        check("rst_data", data_o, 0);
        rst_n = 1'b1;
        #1;
        check("rst_code_ready", code_ready, 1);

        // ce vld data len ordy | rdy valid data wc
        vecs.push_back('{1, 1, 13'h1A5, 4'd9, 1, 1, 0, 16'h0000, 21'd0});
        vecs.push_back('{1, 1, 13'h03F, 4'd7, 1, 1, 0, 16'h0000, 21'd0});
        vecs.push_back('{1, 0, 13'h000, 4'd0, 1, 1, 1, 16'hD2BF, 21'd0});
        vecs.push_back('{0, 1, 13'h1FFF, 4'd13, 1, 0, 1, 16'hD2BF, 21'd0});
        vecs.push_back('{1, 0, 13'h000, 4'd0, 1, 1, 0, 16'h0000, 21'd1});
        vecs.push_back('{1, 1, 13'h000, 4'd0, 1, 1, 0, 16'h0000, 21'd1});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1, 1, 13'h1FF5, 4'd4, 1, 1, 0, 16'h0000, 21'd1});
        vecs.push_back('{1, 0, 13'h000, 4'd0, 1, 1, 1, 16'h5555, 21'd1});
        vecs.push_back('{1, 0, 13'h000, 4'd0, 1, 1, 0, 16'h0000, 21'd2});

        for (int i = 0; i < vecs.size(); i++) begin
            ce = vecs[i].ce; code_valid = vecs[i].vld; code_data = vecs[i].data;
            code_len = vecs[i].len; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("tbl%0d_ready", i), code_ready, vecs[i].exp_rdy);
            tick();
            check($sformatf("tbl%0d_valid", i), valid_o, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), data_o, vecs[i].exp_data);
            check($sformatf("tbl%0d_wc", i), word_cnt, vecs[i].exp_wc);
        end
        ce = 1'b1; code_valid = 1'b0; out_ready = 1'b1;

        // Empty flush: no word, done two cycles after finish, word_cnt cleared after.
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("eflush_done_early", done_o, 0);
        check("eflush_ready_flush", code_ready, 0);
        tick();
        check("eflush_done", done_o, 1);
        check("eflush_wc_at_done", word_cnt, 2);
        tick();
        check("eflush_done_pulse", done_o, 0);
        check("eflush_wc_cleared", word_cnt, 0);
        check("eflush_no_word", valid_o, 0);

        // Flush with a partial tail word.
        beat(13'h0A5, 4'd8);
        beat(13'h03C, 4'd8);
        finish = 1'b1;
        beat(13'h016, 4'd5);
        finish = 1'b0;
        check("flush_first_word", data_o, 16'hA53C);
        wait_done("flush_done_seen", 20, seen);
        check("flush_done_after_hs", cyc - 1, last_hs + 1);
        check("flush_last_word", last_word, 16'hB000);
        check("flush_wc", word_cnt, 2);
        tick();
        check("flush_done_pulse", done_o, 0);
        check("flush_wc_cleared", word_cnt, 0);
        check("flush_sb_empty", exp_q.size(), 0);

        // Backpressure: 40 random 13-bit codes, out_ready low for cycles 5..14.
        for (int i = 0; i < 40; i++) codes[i] = CODE_W'($urandom);
        base = exp_pushed;
        idx  = 0;
        for (int c = 0; c < 300 && idx < 40; c++) begin
            out_ready  = !(c >= 5 && c <= 14);
            code_valid = 1'b1;
            code_data  = codes[idx];
            code_len   = 4'd13;
            #1;
            if (c == 6) held = data_o;
            if (c >= 7 && c <= 14) begin
                check("bp_ready_low", code_ready, 0);
                check("bp_valid_hold", valid_o, 1);
                check("bp_data_hold", data_o, held);
            end
            accepted = code_ready;
            tick();
            if (accepted) idx++;
        end
        code_valid = 1'b0;
        out_ready  = 1'b1;
        check("bp_all_accepted", idx, 40);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_done("bp_done_seen", 100, seen);
        check("bp_word_count", word_cnt, exp_pushed - base);
        check("bp_sb_empty", exp_q.size(), 0);
        tick();

        // Reset mid-stream with a pending word and 9 pending bits.
        out_ready = 1'b0;
        beat(13'h1FFF, 4'd13);
        beat(13'h0AAA, 4'd12);
        tick();
        check("prerst_valid", valid_o, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", valid_o, 0);
        check("midrst_code_ready", code_ready, 1);
        check("midrst_wc", word_cnt, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(13'h0FF, 4'd8);
        beat(13'h0FF, 4'd8);
        drain("rst_sb_empty", 10);
        check("rst_new_word", last_word, 16'hFFFF);
        check("rst_new_wc", word_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encode_pack.md
# encode_pack

Parametrised bit packer that closes the LZS encode pipeline. It accepts variable-length code words (1..CODE_W bits, MSB-first) from the encoder core and packs them into OUT_W-bit output words. The output side uses a valid/ready handshake with backpressure. On finish it flushes a zero-padded final word and pulses done. It replaces the fixed 13→16 packer and adds backpressure, input masking, explicit flush and a word counter.

## Interface
Parameters:
- OUT_W, 16, output word width (≥ 8)
- CODE_W, 13, maximum code length (1..OUT_W)
- LEN_W, 4, width of code_len (2^LEN_W > CODE_W)
- CNT_W, 21, width of per-stream word counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ce  in  1  clock enable; low freezes all state
- code_valid  in  1  code beat present
- code_data  in  CODE_W  code, right-aligned
- code_len  in  LEN_W  valid bits in code_data, 0..CODE_W
- code_ready  out  1  beat accepted when code_valid & code_ready
- finish  in  1  end of stream; sampled only in RUN with ce high
- data_o  out  OUT_W  packed word, first code bit in MSB
- valid_o  out  1  data_o valid
- out_ready  in  1  downstream accepts when valid_o & out_ready & ce
- done_o  out  1  one-cycle pulse: stream fully emitted
- word_cnt  out  CNT_W  words emitted in current stream

## Operation
- State: accumulator acc[OUT_W+CODE_W-2:0], bit count cnt (0..OUT_W+CODE_W-1), FSM {RUN, FLUSH, DONE}, output register.
- Masking: bits of code_data at or above code_len are forced to zero. code_len = 0 is a legal no-op beat. code_len > CODE_W is illegal; the bench asserts on it.
- emit = cnt ≥ OUT_W & (!valid_o | out_ready). On emit, data_o ← acc[cnt-1 -: OUT_W], valid_o ← 1, cnt −= OUT_W.
- cnt_avail = emit ? cnt−OUT_W : cnt.
- code_ready = ce & state==RUN & cnt_avail < OUT_W. This is combinational from out_ready.
- On accept: acc ← (acc << code_len) | masked code; cnt ← cnt_avail + code_len. Accept and emit can occur in the same cycle; emit uses the pre-shift acc.
- valid_o clears when accepted and no new emit occurs in that cycle.
- FSM:
  - RUN → FLUSH on finish. A code beat in the same cycle is accepted first.
  - FLUSH: drain full words. When cnt < OUT_W and the output register is free:
    - if cnt > 0, emit one word = remaining bits left-justified, LSBs zero; cnt ← 0.
    - if cnt == 0 and the output register is empty (no valid_o pending), go to DONE.
  - DONE: done_o = 1 for one cycle; word_cnt clears; next state RUN.
- word_cnt increments on each output handshake (valid_o & out_ready & ce) and saturates at all-ones.
- ce low: no register changes, code_ready = 0, outputs held, out_ready ignored.
- Reset values: data_o 0, valid_o 0, done_o 0, word_cnt 0, cnt 0, acc 0, state RUN.

## Timing
- Latency: a beat accepted at edge N that brings cnt ≥ OUT_W gives valid_o high after edge N+1, if the output register is free.
- Throughput: sustained one code per cycle and one word per cycle with out_ready held high.
- Backpressure: data_o/valid_o hold stable while valid_o & !out_ready. code_ready drops once cnt_avail ≥ OUT_W. No bits are lost or duplicated.
- done_o rises the cycle after the last word handshake completes. If finish arrives with cnt = 0 and the output is idle, done_o rises 2 cycles after finish (RUN→FLUSH→DONE).
- finish in FLUSH or DONE is ignored.
- Reset mid-stream: at the first edge with rst_n low, all state takes reset values. Pending bits and any valid_o word are discarded.

## Structure
- Shared package encode_pkg: FSM state enum (RUN/FLUSH/DONE), ACC_W = OUT_W+CODE_W−1, CNTB_W = $clog2(OUT_W+CODE_W).
- One sub-module, encode_pack_acc: accumulator, cnt, masking and the emit extractor.
- FSM, output register and word_cnt stay in encode_pack.

## Test plan
- Defaults, out_ready=1: codes (0x1A5, len 9), (0x3F, len 7) → one word 0xD2BF; word_cnt=1.
- Masking: four beats code_data=0x1FF5, len 4 → single word 0x5555.
- Backpressure: stream 40 random 13-bit codes, out_ready low for cycles 5–14.
  - code_ready falls within 2 cycles.
  - data_o stable while stalled.
  - word sequence matches the reference model bit-exactly.
- Flush: 16 bits then (0b10110, len 5) + finish → words 0x…, then 0xB000; done_o pulses the cycle after the last handshake; word_cnt=2 then 0.
- Empty flush: finish with no data → no word; done_o high exactly 2 cycles after finish.
- Reset mid-stream with valid_o=1 and cnt=9: the next cycle shows valid_o=0 and code_ready=1. A new stream (0xFFFF as 2×len 8) yields 0xFFFF with no stale bits.
